// File: rtl/ps2_digit_tx.sv
// Device-side PS/2 transmitter: decimal digit -> set-2 make code, serialized as 11-bit frames.
// Define PS2_BREAK_EN to follow each make frame with the break sequence (F0h, code).
`timescale 1ns/1ps

module ps2_digit_tx #(
  parameter int CLK_DIV = 4,  // system clocks per PS/2 clock half-period, >= 2
  parameter int GAP_CYC = 8   // idle cycles after every frame, >= 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  output logic       ready,
  input  logic       inhibit,
  output logic       err,
  output logic       busy,
  output logic       ps2_clk,
  output logic       ps2_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_BIT,
    S_GAP,
    S_HOLD
  } state_t;

`ifdef PS2_BREAK_EN
  localparam logic [1:0] N_FRAMES = 2'd3;
`else
  localparam logic [1:0] N_FRAMES = 2'd1;
`endif

  localparam int TMR_MAX = (2 * CLK_DIV > GAP_CYC) ? 2 * CLK_DIV : GAP_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [TMR_W-1:0] HALF_END = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] BIT_END  = TMR_W'(2 * CLK_DIV - 1);
  localparam logic [TMR_W-1:0] GAP_END  = TMR_W'(GAP_CYC - 1);
  localparam logic [3:0]       STOP_IDX = 4'd10;

  function automatic logic [7:0] make_code(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0:    c = 8'h45;
      4'd1:    c = 8'h16;
      4'd2:    c = 8'h1E;
      4'd3:    c = 8'h26;
      4'd4:    c = 8'h25;
      4'd5:    c = 8'h2E;
      4'd6:    c = 8'h36;
      4'd7:    c = 8'h3D;
      4'd8:    c = 8'h3E;
      default: c = 8'h46;
    endcase
    return c;
  endfunction

  state_t           state, state_n;
  logic [TMR_W-1:0] tmr, tmr_n;
  logic [3:0]       bit_idx, bit_idx_n;
  logic [1:0]       frame_idx, frame_idx_n;
  logic [7:0]       code, code_n;
  logic             clk_q, clk_n;
  logic             data_q, data_n;
  logic             err_q, err_n;

  logic [7:0]  cur_byte;
  logic [10:0] frame_bits;
  logic [3:0]  bit_nxt;

  // Middle frame of a break sequence carries F0h; every other frame carries the make code.
  assign cur_byte   = (frame_idx == 2'd1) ? 8'hF0 : code;
  assign frame_bits = {1'b1, ~^cur_byte, cur_byte, 1'b0};
  assign bit_nxt    = bit_idx + 4'd1;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_n     = state;
    tmr_n       = tmr;
    bit_idx_n   = bit_idx;
    frame_idx_n = frame_idx;
    code_n      = code;
    clk_n       = clk_q;
    data_n      = data_q;
    err_n       = 1'b0;

    case (state)
      S_IDLE: begin
        clk_n  = 1'b1;
        data_n = 1'b1;
        if (digit_valid) begin
          if (digit > 4'd9) begin
            err_n = 1'b1;
          end else begin
            code_n      = make_code(digit);
            frame_idx_n = 2'd0;
            state_n     = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (!inhibit) begin
          state_n   = S_BIT;
          bit_idx_n = 4'd0;
          tmr_n     = '0;
          clk_n     = 1'b1;
          data_n    = frame_bits[0];
        end
      end

      S_BIT: begin
        if (inhibit && bit_idx != STOP_IDX) begin
          // Host pulled the clock before the stop bit: abort and release both lines.
          state_n = S_HOLD;
          tmr_n   = '0;
          clk_n   = 1'b1;
          data_n  = 1'b1;
        end else if (tmr == BIT_END) begin
          tmr_n = '0;
          clk_n = 1'b1;
          if (bit_idx == STOP_IDX) begin
            state_n     = S_GAP;
            frame_idx_n = frame_idx + 2'd1;
            data_n      = 1'b1;
          end else begin
            bit_idx_n = bit_nxt;
            data_n    = frame_bits[bit_nxt];
          end
        end else begin
          tmr_n = tmr + TMR_W'(1);
          if (tmr == HALF_END) clk_n = 1'b0;
        end
      end

      S_GAP: begin
        if (tmr == GAP_END) begin
          tmr_n   = '0;
          state_n = (frame_idx == N_FRAMES) ? S_IDLE : S_WAIT;
        end else begin
          tmr_n = tmr + TMR_W'(1);
        end
      end

      S_HOLD: begin
        if (!inhibit) begin
          state_n = S_GAP;
          tmr_n   = '0;
        end
      end

      default: begin
        state_n = S_IDLE;
        clk_n   = 1'b1;
        data_n  = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: every register here, including the latched code, is reset so a mid-frame reset discards the sequence.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      tmr       <= '0;
      bit_idx   <= 4'd0;
      frame_idx <= 2'd0;
      code      <= 8'h00;
      clk_q     <= 1'b1;
      data_q    <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      tmr       <= tmr_n;
      bit_idx   <= bit_idx_n;
      frame_idx <= frame_idx_n;
      code      <= code_n;
      clk_q     <= clk_n;
      data_q    <= data_n;
      err_q     <= err_n;
    end
  end

  assign ready    = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign err      = err_q;
  assign ps2_clk  = clk_q;
  assign ps2_data = data_q;

endmodule

// File: tb/tb_ps2_digit_tx.sv
// Directed testbench for ps2_digit_tx: decodes frames on ps2_clk falling edges and checks timing.
// Expectations adapt to PS2_BREAK_EN (three frames per digit) when that macro is defined.
`timescale 1ns/1ps

module tb_ps2_digit_tx;

`ifdef PS2_BREAK_EN
  localparam int N_FR = 3;
`else
  localparam int N_FR = 1;
`endif
  localparam int XFER = 97;  // 1 + 22*4 + 8 cycles per frame slot

  // {stop, parity, data[7:0], start}; bit i is the i-th value sampled on a falling edge
  localparam logic [10:0] F16 = 11'b1_0_00010110_0;
  localparam logic [10:0] F45 = 11'b1_0_01000101_0;
  localparam logic [10:0] FF0 = 11'b1_1_11110000_0;
  localparam logic [10:0] F3D = 11'b1_0_00111101_0;
  localparam logic [10:0] F2E = 11'b1_1_00101110_0;

  logic       clk;
  logic       resetn;
  logic [3:0] digit;
  logic       digit_valid;
  logic       ready;
  logic       inhibit;
  logic       err;
  logic       busy;
  logic       ps2_clk;
  logic       ps2_data;

  int errors = 0;
  int checks = 0;

  logic fall_bit [0:63];
  int   fall_cyc [0:63];
  int   n_falls;
  int   ready_cyc;
  int   quiet_bad;
  logic e_ready;
  logic e_busy;

  ps2_digit_tx #(.CLK_DIV(4), .GAP_CYC(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .digit       (digit),
    .digit_valid (digit_valid),
    .ready       (ready),
    .inhibit     (inhibit),
    .err         (err),
    .busy        (busy),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  // Presents digit d for one accepting edge E, then watches the lines for up to 2000 cycles.
  // Cycle numbers count edges after E; inhibit and a busy-time digit_valid are driven on schedule.
  task automatic run_xfer(input logic [3:0] d, input logic inh0,
                          input int inh_on, input int inh_off,
                          input int noise_on, input int noise_off,
                          input int quiet_from, input int quiet_to);
    logic prev;
    n_falls   = 0;
    ready_cyc = 0;
    quiet_bad = 0;
    digit       = d;
    digit_valid = 1'b1;
    inhibit     = inh0;
    @(posedge clk); #1;
    digit_valid = 1'b0;
    e_ready = ready;
    e_busy  = busy;
    prev    = ps2_clk;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(posedge clk); #1;
      if (prev && !ps2_clk && n_falls < 64) begin
        fall_bit[n_falls] = ps2_data;
        fall_cyc[n_falls] = cyc;
        n_falls++;
      end
      prev = ps2_clk;
      if (cyc >= quiet_from && cyc <= quiet_to && !(ps2_clk && ps2_data)) quiet_bad++;
      if (ready) begin
        ready_cyc = cyc;
        break;
      end
      if (cyc == inh_on)  inhibit = 1'b1;
      if (cyc == inh_off) inhibit = 1'b0;
      if (cyc == noise_on) begin
        digit       = 4'd9;
        digit_valid = 1'b1;
      end
      if (cyc == noise_off) digit_valid = 1'b0;
    end
    inhibit     = 1'b0;
    digit_valid = 1'b0;
  endtask

  function automatic logic [10:0] frame_at(input int off);
    logic [10:0] v;
    for (int i = 0; i < 11; i++) v[i] = (off + i < 64) ? fall_bit[off + i] : 1'bx;
    return v;
  endfunction

  function automatic logic [10:0] exp_frame(input logic [10:0] code_frame, input int k);
    return (N_FR == 3 && k == 1) ? FF0 : code_frame;
  endfunction

  task automatic test_reset;
    resetn      = 1'b0;
    digit       = 4'd0;
    digit_valid = 1'b0;
    inhibit     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b1)    begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (err !== 1'b0)      begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ps2_clk !== 1'b1)  begin errors++; $display("FAIL reset_ps2_clk: got %b want 1", ps2_clk); end
    checks++; if (ps2_data !== 1'b1) begin errors++; $display("FAIL reset_ps2_data: got %b want 1", ps2_data); end
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL post_reset_idle: ready=%b busy=%b want 1/0", ready, busy); end
  endtask

  // Digit d sent with no inhibit; also presents a second digit while busy, which must be ignored.
  task automatic test_frames(input logic [3:0] d, input logic [10:0] code_frame, input int noise_on);
    run_xfer(d, 1'b0, -1, -1, noise_on, noise_on + 10, 89, 97);
    checks++; if (e_ready !== 1'b0 || e_busy !== 1'b1)
      begin errors++; $display("FAIL d%0d_accept: ready=%b busy=%b want 0/1", d, e_ready, e_busy); end
    checks++; if (n_falls !== 11 * N_FR)
      begin errors++; $display("FAIL d%0d_fall_count: got %0d want %0d", d, n_falls, 11 * N_FR); end
    for (int k = 0; k < N_FR; k++) begin
      checks++; if (frame_at(11 * k) !== exp_frame(code_frame, k))
        begin errors++; $display("FAIL d%0d_frame%0d: got %b want %b", d, k, frame_at(11 * k), exp_frame(code_frame, k)); end
      checks++; if (fall_cyc[11 * k] !== XFER * k + 5)
        begin errors++; $display("FAIL d%0d_frame%0d_first_fall: cycle %0d want %0d", d, k, fall_cyc[11 * k], XFER * k + 5); end
    end
    checks++; if (ready_cyc !== XFER * N_FR)
      begin errors++; $display("FAIL d%0d_ready_return: cycle %0d want %0d", d, ready_cyc, XFER * N_FR); end
    checks++; if (quiet_bad !== 0)
      begin errors++; $display("FAIL d%0d_gap_idle: %0d non-idle cycles want 0", d, quiet_bad); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || ps2_clk !== 1'b1)
      begin errors++; $display("FAIL d%0d_not_queued: busy=%b ps2_clk=%b want 0/1", d, busy, ps2_clk); end
  endtask

  task automatic test_bad_digit;
    int bad;
    digit       = 4'd12;
    digit_valid = 1'b1;
    @(posedge clk); #1;
    digit_valid = 1'b0;
    checks++; if (err !== 1'b1)   begin errors++; $display("FAIL bad_err_pulse: got %b want 1", err); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL bad_ready: got %b want 1", ready); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL bad_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    checks++; if (err !== 1'b0)   begin errors++; $display("FAIL bad_err_width: got %b want 0", err); end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (!(ps2_clk && ps2_data && ready)) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bad_lines_idle: %0d bad cycles want 0", bad); end
  endtask

  // digit 7; inhibit raised during data bit 3 (cycles 33..40) and held for 20 cycles
  task automatic test_inhibit_abort;
    run_xfer(4'd7, 1'b0, 35, 55, -1, -1, 36, 64);
    checks++; if (n_falls !== 4 + 11 * N_FR)
      begin errors++; $display("FAIL abort_fall_count: got %0d want %0d", n_falls, 4 + 11 * N_FR); end
    checks++; if (quiet_bad !== 0)
      begin errors++; $display("FAIL abort_lines_high: %0d non-idle cycles want 0", quiet_bad); end
    for (int k = 0; k < N_FR; k++) begin
      checks++; if (frame_at(4 + 11 * k) !== exp_frame(F3D, k))
        begin errors++; $display("FAIL abort_resend_frame%0d: got %b want %b", k, frame_at(4 + 11 * k), exp_frame(F3D, k)); end
    end
    checks++; if (fall_cyc[4] !== 69)
      begin errors++; $display("FAIL abort_resend_start: cycle %0d want 69", fall_cyc[4]); end
    checks++; if (ready_cyc !== 161 + XFER * (N_FR - 1))
      begin errors++; $display("FAIL abort_ready_return: cycle %0d want %0d", ready_cyc, 161 + XFER * (N_FR - 1)); end
  endtask

  // digit 5 accepted with inhibit high; inhibit released after cycle 30
  task automatic test_inhibit_wait;
    run_xfer(4'd5, 1'b1, -1, 30, -1, -1, 1, 30);
    checks++; if (e_busy !== 1'b1)
      begin errors++; $display("FAIL wait_busy: got %b want 1", e_busy); end
    checks++; if (quiet_bad !== 0)
      begin errors++; $display("FAIL wait_no_activity: %0d non-idle cycles want 0", quiet_bad); end
    checks++; if (n_falls !== 11 * N_FR)
      begin errors++; $display("FAIL wait_fall_count: got %0d want %0d", n_falls, 11 * N_FR); end
    checks++; if (frame_at(0) !== F2E)
      begin errors++; $display("FAIL wait_frame: got %b want %b", frame_at(0), F2E); end
    checks++; if (fall_cyc[0] !== 35)
      begin errors++; $display("FAIL wait_first_fall: cycle %0d want 35", fall_cyc[0]); end
    checks++; if (ready_cyc !== 127 + XFER * (N_FR - 1))
      begin errors++; $display("FAIL wait_ready_return: cycle %0d want %0d", ready_cyc, 127 + XFER * (N_FR - 1)); end
  endtask

  // digit 4 (25h); at cycle 22 the block is in data bit 1 (0) with ps2_clk low
  task automatic test_reset_mid;
    int bad;
    digit       = 4'd4;
    digit_valid = 1'b1;
    @(posedge clk); #1;
    digit_valid = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    checks++; if (ps2_clk !== 1'b0 || ps2_data !== 1'b0)
      begin errors++; $display("FAIL mid_frame_lines: clk=%b data=%b want 0/0", ps2_clk, ps2_data); end
    resetn = 1'b0;
    #1;
    checks++; if (ps2_clk !== 1'b1)  begin errors++; $display("FAIL mid_reset_clk: got %b want 1", ps2_clk); end
    checks++; if (ps2_data !== 1'b1) begin errors++; $display("FAIL mid_reset_data: got %b want 1", ps2_data); end
    checks++; if (ready !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL mid_reset_ready: ready=%b busy=%b want 1/0", ready, busy); end
    @(posedge clk); #1;
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy || !ps2_clk || !ps2_data) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mid_reset_discard: %0d active cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_frames(4'd1, F16, 10);
    test_frames(4'd0, F45, -1);
    test_bad_digit();
    test_inhibit_abort();
    test_inhibit_wait();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
